// File: rtl/ser_nibble_loader.sv
// Serial-to-parallel nibble loader: assembles 4 MSB-first bits, optionally checks an
// even-parity bit, then presents the nibble with a one-cycle load strobe.
module ser_nibble_loader #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       abort,
  output logic [3:0] d_out,
  output logic       load,
  output logic       busy,
  output logic       par_err,
  output logic [7:0] nib_cnt
);

  // state  | meaning
  // IDLE   | waiting for start
  // SHIFT  | collecting the four data bits
  // PARITY | waiting for the even-parity bit
  // LOAD   | nibble delivered this cycle; start here chains the next frame
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOAD} state_t;

  state_t     state;
  logic [3:0] sreg;
  logic [2:0] bit_cnt;
  logic [3:0] nxt_nib;

  assign nxt_nib = {sreg[2:0], sin};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= 4'b0000;
      bit_cnt <= 3'd0;
      d_out   <= 4'b0000;
      load    <= 1'b0;
      par_err <= 1'b0;
      nib_cnt <= 8'd0;
    end else begin
      load <= 1'b0;
      if (abort) begin
        // An abort in LOAD lands after the strobe was already registered.
        state   <= IDLE;
        sreg    <= 4'b0000;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= SHIFT;
              sreg    <= 4'b0000;
              bit_cnt <= 3'd0;
              par_err <= 1'b0;
            end
          end
          SHIFT: begin
            if (sin_valid) begin
              sreg    <= nxt_nib;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd3) begin
                if (PARITY_EN) begin
                  state <= PARITY;
                end else begin
                  state   <= LOAD;
                  d_out   <= nxt_nib;
                  load    <= 1'b1;
                  nib_cnt <= nib_cnt + 8'd1;
                end
              end
            end
          end
          PARITY: begin
            if (sin_valid) begin
              if (sin == ^sreg) begin
                state   <= LOAD;
                d_out   <= sreg;
                load    <= 1'b1;
                nib_cnt <= nib_cnt + 8'd1;
              end else begin
                state   <= IDLE;
                par_err <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (start) begin
              state   <= SHIFT;
              sreg    <= 4'b0000;
              bit_cnt <= 3'd0;
              par_err <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ser_nibble_loader.sv
// Directed vector table plus hand sequences for reset, back-to-back and wrap corners.
module tb_ser_nibble_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, sin, sin_valid, abort;
  logic [3:0] d_out, d_out0;
  logic       load, busy, par_err, load0, busy0, par_err0;
  logic [7:0] nib_cnt, nib_cnt0;

  int total = 0;
  int bad   = 0;

  ser_nibble_loader #(.PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid), .abort(abort),
    .d_out(d_out), .load(load), .busy(busy), .par_err(par_err), .nib_cnt(nib_cnt)
  );

  ser_nibble_loader #(.PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid), .abort(abort),
    .d_out(d_out0), .load(load0), .busy(busy0), .par_err(par_err0), .nib_cnt(nib_cnt0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, si, va, ab;
    logic       ld;
    logic [3:0] d;
    logic       bsy, perr;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];

  task automatic v(input logic st, si, va, ab, input logic ld, input logic [3:0] d,
                   input logic bsy, perr, input logic [7:0] cnt);
    vec_t e;
    e.st = st; e.si = si; e.va = va; e.ab = ab;
    e.ld = ld; e.d = d; e.bsy = bsy; e.perr = perr; e.cnt = cnt;
    vt.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, si, va, ab);
    @(negedge clk);
    start = st; sin = si; sin_valid = va; abort = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int p_first, p_second;
    logic [3:0] d_first, d_second;
    bit sa [0:10];
    bit ba [0:10];
    bit va [0:10];

    rst = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0; abort = 1'b0;
    #1;
    chk("reset_outputs", {27'd0, load, d_out, busy, par_err, nib_cnt[0]},
        32'd0);
    chk("reset_nib_cnt", {24'd0, nib_cnt}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // start, sin, valid, abort | load, d_out, busy, par_err, nib_cnt
    v(1,0,0,0, 0,4'h0,1,0,0);
    v(0,1,1,0, 0,4'h0,1,0,0);
    v(0,1,1,0, 0,4'h0,1,0,0);
    v(0,0,1,0, 0,4'h0,1,0,0);
    v(0,0,1,0, 0,4'h0,1,0,0);
    v(0,0,1,0, 1,4'hC,1,0,1);
    v(0,0,0,0, 0,4'hC,0,0,1);
    // parity error: 1000 with parity 0
    v(1,0,0,0, 0,4'hC,1,0,1);
    v(0,1,1,0, 0,4'hC,1,0,1);
    v(0,0,1,0, 0,4'hC,1,0,1);
    v(0,0,1,0, 0,4'hC,1,0,1);
    v(0,0,1,0, 0,4'hC,1,0,1);
    v(0,0,1,0, 0,4'hC,0,1,1);
    v(0,0,0,0, 0,4'hC,0,1,1);
    // 1010/0 with three stall cycles between bits; start ignored while busy
    v(1,0,0,0, 0,4'hC,1,0,1);
    v(0,1,1,0, 0,4'hC,1,0,1);
    v(1,0,0,0, 0,4'hC,1,0,1);
    v(1,0,0,0, 0,4'hC,1,0,1);
    v(1,0,0,0, 0,4'hC,1,0,1);
    v(0,0,1,0, 0,4'hC,1,0,1);
    v(1,1,0,0, 0,4'hC,1,0,1);
    v(1,1,0,0, 0,4'hC,1,0,1);
    v(1,1,0,0, 0,4'hC,1,0,1);
    v(0,1,1,0, 0,4'hC,1,0,1);
    v(0,0,0,0, 0,4'hC,1,0,1);
    v(0,0,0,0, 0,4'hC,1,0,1);
    v(0,0,0,0, 0,4'hC,1,0,1);
    v(0,0,1,0, 0,4'hC,1,0,1);
    v(1,1,0,0, 0,4'hC,1,0,1);
    v(0,0,1,0, 1,4'hA,1,0,2);
    v(0,0,0,0, 0,4'hA,0,0,2);
    // abort after two bits (beats start and sin_valid), then 0110/0
    v(1,0,0,0, 0,4'hA,1,0,2);
    v(0,0,1,0, 0,4'hA,1,0,2);
    v(0,1,1,0, 0,4'hA,1,0,2);
    v(1,1,1,1, 0,4'hA,0,0,2);
    v(1,0,0,0, 0,4'hA,1,0,2);
    v(0,0,1,0, 0,4'hA,1,0,2);
    v(0,1,1,0, 0,4'hA,1,0,2);
    v(0,1,1,0, 0,4'hA,1,0,2);
    v(0,0,1,0, 0,4'hA,1,0,2);
    v(0,0,1,0, 1,4'h6,1,0,3);
    v(0,0,0,0, 0,4'h6,0,0,3);
    v(1,0,0,1, 0,4'h6,0,0,3);
    // 0111 with parity 1, then chained frame 1111/0 via start in LOAD
    v(1,0,0,0, 0,4'h6,1,0,3);
    v(0,0,1,0, 0,4'h6,1,0,3);
    v(0,1,1,0, 0,4'h6,1,0,3);
    v(0,1,1,0, 0,4'h6,1,0,3);
    v(0,1,1,0, 0,4'h6,1,0,3);
    v(0,1,1,0, 1,4'h7,1,0,4);
    v(1,0,0,0, 0,4'h7,1,0,4);
    v(0,1,1,0, 0,4'h7,1,0,4);
    v(0,1,1,0, 0,4'h7,1,0,4);
    v(0,1,1,0, 0,4'h7,1,0,4);
    v(0,1,1,0, 0,4'h7,1,0,4);
    v(0,0,1,0, 1,4'hF,1,0,5);
    v(1,0,0,1, 0,4'hF,0,0,5);
    // abort while waiting for a parity bit that would have been good
    v(1,0,0,0, 0,4'hF,1,0,5);
    v(0,1,1,0, 0,4'hF,1,0,5);
    v(0,0,1,0, 0,4'hF,1,0,5);
    v(0,0,1,0, 0,4'hF,1,0,5);
    v(0,1,1,0, 0,4'hF,1,0,5);
    v(0,0,1,1, 0,4'hF,0,0,5);
    v(0,0,0,0, 0,4'hF,0,0,5);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].st, vt[i].si, vt[i].va, vt[i].ab);
      chk($sformatf("vec[%0d] {load,d_out,busy,par_err,nib_cnt}", i),
          {17'd0, load, d_out, busy, par_err, nib_cnt},
          {17'd0, vt[i].ld, vt[i].d, vt[i].bsy, vt[i].perr, vt[i].cnt});
    end

    // asynchronous reset in the middle of a clock period during SHIFT
    step(1,0,0,0);
    step(0,1,1,0);
    step(0,0,1,0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {17'd0, load, d_out, busy, par_err, nib_cnt}, 32'd0);
    @(posedge clk); #1;
    chk("rst_held_load", {31'd0, load}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0,1,1,0);
    chk("post_rst_idle", {17'd0, load, d_out, busy, par_err, nib_cnt}, 32'd0);

    // no-parity instance: 1100 then 0011 with start in the LOAD cycle
    sa = '{1,0,0,0,0,1,0,0,0,0,0};
    ba = '{0,1,1,0,0,0,0,0,1,1,0};
    va = '{0,1,1,1,1,0,1,1,1,1,0};
    pulses = 0; p_first = -1; p_second = -1; d_first = 4'h0; d_second = 4'h0;
    for (int i = 0; i < 11; i++) begin
      step(sa[i], ba[i], va[i], 1'b0);
      if (load0 === 1'b1) begin
        pulses++;
        if (pulses == 1) begin p_first = i; d_first = d_out0; end
        else if (pulses == 2) begin p_second = i; d_second = d_out0; end
      end
    end
    chk("b2b_pulse_count", pulses, 2);
    chk("b2b_low_cycles_between", p_second - p_first - 1, 4);
    chk("b2b_first_nibble", {28'd0, d_first}, 32'hC);
    chk("b2b_second_nibble", {28'd0, d_second}, 32'h3);
    chk("b2b_nib_cnt", {24'd0, nib_cnt0}, 32'd2);
    chk("b2b_busy_after", {31'd0, busy0}, 32'd0);

    // wrap nib_cnt 255 -> 0 on the no-parity instance
    for (int f = 0; f < 253; f++) begin
      step(1,0,0,0);
      for (int b = 0; b < 4; b++) step(0, b[0], 1, 0);
      step(0,0,0,0);
    end
    chk("nib_cnt_at_255", {24'd0, nib_cnt0}, 32'd255);
    step(1,0,0,0);
    step(0,1,1,0); step(0,0,1,0); step(0,0,1,0); step(0,1,1,0);
    chk("wrap_load", {31'd0, load0}, 32'd1);
    step(0,0,0,0);
    chk("nib_cnt_wrap_0", {24'd0, nib_cnt0}, 32'd0);
    chk("wrap_nibble", {28'd0, d_out0}, 32'h9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ser_nibble_loader.md
SER_NIBBLE_LOADER -- requirements
Module: ser_nibble_loader

Interface
REQ-001 SHALL have parameter: PARITY_EN, 1, 1 = even-parity bit follows each nibble; 0 = no parity bit.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  frame start request, sampled on clk.
REQ-005 SHALL have port: sin  input  1  serial data bit, MSB first.
REQ-006 SHALL have port: sin_valid  input  1  qualifies sin; bit accepted only when high.
REQ-007 SHALL have port: abort  input  1  synchronous frame abort.
REQ-008 SHALL have port: d_out  output  4  assembled nibble, drives downstream register data input.
REQ-009 SHALL have port: load  output  1  one-cycle load strobe to downstream register.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: par_err  output  1  sticky parity-error flag.
REQ-012 SHALL have port: nib_cnt  output  8  count of nibbles successfully delivered.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, PARITY, LOAD; busy = (state != IDLE).
REQ-014 SHALL, in IDLE with start=1, go to SHIFT with bit counter 0 and clear par_err.
REQ-015 SHALL, in SHIFT, on each edge with sin_valid=1 shift sin into a 4-bit shift register at LSB with prior bits moving left (first bit ends in bit 3); counter +1.
REQ-016 SHALL hold shift register and counter when sin_valid=0 (stall, no timeout).
REQ-017 SHALL, on the edge accepting the 4th data bit, go to PARITY if PARITY_EN=1, else LOAD.
REQ-018 SHALL, in PARITY with sin_valid=1, go to LOAD if sin equals XOR of the 4 data bits; otherwise go to IDLE, set par_err=1, not assert load, not change d_out.
REQ-019 SHALL register d_out and load: the edge entering LOAD sets d_out = nibble and load=1; load is high for exactly one clock period.
REQ-020 SHALL hold d_out at last delivered nibble until next delivery.
REQ-021 SHALL increment nib_cnt by 1 per load pulse, wrapping 255 -> 0.
REQ-022 SHALL, in LOAD, go to SHIFT if start=1 (back-to-back frames, par_err cleared), else IDLE.
REQ-023 SHALL ignore start in SHIFT and PARITY.
REQ-024 SHALL, on abort=1 in any state, go to IDLE next edge, discard partial nibble, leave d_out/nib_cnt/par_err unchanged; abort has priority over start and sin_valid; an abort in LOAD does not cancel the load pulse already issued.
REQ-025 SHALL keep par_err set until next accepted start or reset.

Reset
REQ-026 SHALL on rst=1, immediately and independent of clk: state=IDLE, shift register=0, counter=0, d_out=4'b0000, load=0, busy=0, par_err=0, nib_cnt=0.
REQ-027 SHALL, on reset mid-frame, drop the frame with no load pulse; first edge after rst deasserts behaves as IDLE.

Verification
REQ-028 SHALL cover: reset, start, bits 1,1,0,0 with sin_valid=1, parity 0 -> d_out=4'b1100, load high one cycle, nib_cnt=1, busy low after.
REQ-029 SHALL cover: bits 1,0,0,0, parity 0 -> par_err=1, load never high, d_out unchanged, state IDLE.
REQ-030 SHALL cover: frame 1010/0 with sin_valid low 3 cycles between bits -> d_out=4'b1010 delivered once, no extra shifts.
REQ-031 SHALL cover: abort after 2 bits, then full frame 0110/0 -> only 4'b0110 delivered, nib_cnt increments by 1.
REQ-032 SHALL cover: rst asserted mid-clock during SHIFT -> all outputs zero without clock edge, no load.
REQ-033 SHALL cover: PARITY_EN=0, two back-to-back frames 1100 then 0011 with start in LOAD cycle -> two load pulses separated by 4 cycles, nib_cnt=2.
